// File: rtl/mem_responder.sv
// mem_responder: memory-interface target with ROM/RAM array, memory-mapped I/O ports and a program-load port
module mem_responder #(
  parameter logic [7:0] ROM_TOP = 8'h7F,
  parameter logic [7:0] RAM_TOP = 8'hDF,
  parameter int         N_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mar_load,
  input  logic [7:0]           addr_in,
  input  logic                 write,
  input  logic [7:0]           data_in,
  output logic [7:0]           from_memory,
  input  logic                 prog_we,
  input  logic [7:0]           prog_addr,
  input  logic [7:0]           prog_data,
  input  logic [8*N_PORTS-1:0] port_in,
  output logic [8*N_PORTS-1:0] port_out,
  output logic [7:0]           mar_out,
  output logic                 rom_wr_err,
  output logic                 unmapped_err
);
  localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
  logic [7:0] mem [256];
  logic [7:0] out_q [N_PORTS];
  logic [7:0] sync1 [N_PORTS];
  logic [7:0] sync2 [N_PORTS];
  logic [7:0] mar;
  logic [7:0] rd;
  logic       wr_ram, wr_out;
  function automatic logic f_rom(input logic [7:0] a);
    return a <= ROM_TOP;
  endfunction
  function automatic logic f_mem(input logic [7:0] a);
    return a <= RAM_TOP;
  endfunction
  function automatic logic f_out(input logic [7:0] a);
    return a[7:4] == 4'hE && {1'b0, a[3:0]} < 5'(N_PORTS);
  endfunction
  function automatic logic f_in(input logic [7:0] a);
    return a[7:4] == 4'hF && {1'b0, a[3:0]} < 5'(N_PORTS);
  endfunction
  function automatic logic f_unm(input logic [7:0] a);
    return !f_mem(a) && !f_out(a) && !f_in(a);
  endfunction
  always_comb begin
    rd = f_mem(addr_in) ? mem[addr_in] :
         f_out(addr_in) ? out_q[addr_in[PW-1:0]] :
         f_in(addr_in)  ? sync2[addr_in[PW-1:0]] : 8'h00;
    wr_ram = write && !f_rom(mar) && f_mem(mar);
    wr_out = write && f_out(mar);
  end
  // Program load is written last so it wins a same-address collision with a CPU store.
  always_ff @(posedge clk) begin
    if (wr_ram) mem[mar] <= data_in;
    if (prog_we && prog_addr <= RAM_TOP) mem[prog_addr] <= prog_data;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar          <= 8'h00;
      from_memory  <= 8'h00;
      rom_wr_err   <= 1'b0;
      unmapped_err <= 1'b0;
      for (int k = 0; k < N_PORTS; k++) begin
        out_q[k] <= 8'h00;
        sync1[k] <= 8'h00;
        sync2[k] <= 8'h00;
      end
    end else begin
      mar         <= mar_load ? addr_in : mar;
      from_memory <= mar_load ? rd : (wr_ram || wr_out) ? data_in : from_memory;
      if (wr_out) out_q[mar[PW-1:0]] <= data_in;
      if (write && f_rom(mar)) rom_wr_err <= 1'b1;
      if ((mar_load && f_unm(addr_in)) || (write && f_unm(mar))) unmapped_err <= 1'b1;
      for (int k = 0; k < N_PORTS; k++) begin
        sync1[k] <= port_in[8*k +: 8];
        sync2[k] <= sync1[k];
      end
    end
  end
  for (genvar g = 0; g < N_PORTS; g++) begin : g_po
    assign port_out[8*g +: 8] = out_q[g];
  end
  assign mar_out = mar;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against an address-map reference model
module tb_mem_responder;
  localparam int N = 4;
  localparam logic [7:0] ROM_TOP = 8'h7F;
  localparam logic [7:0] RAM_TOP = 8'hDF;
  logic clk = 0, reset = 1, mar_load = 0, write = 0, prog_we = 0;
  logic [7:0] addr_in = 0, data_in = 0, prog_addr = 0, prog_data = 0;
  logic [8*N-1:0] port_in = 0, port_out;
  logic [7:0] from_memory, mar_out;
  logic rom_wr_err, unmapped_err;

  mem_responder #(.ROM_TOP(ROM_TOP), .RAM_TOP(RAM_TOP), .N_PORTS(N)) dut (
    .clk(clk), .reset(reset), .mar_load(mar_load), .addr_in(addr_in), .write(write),
    .data_in(data_in), .from_memory(from_memory), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .port_in(port_in), .port_out(port_out), .mar_out(mar_out),
    .rom_wr_err(rom_wr_err), .unmapped_err(unmapped_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] fm, mar;
    logic [8*N-1:0] po;
    logic re, ue;
    string tag;
  } exp_t;
  exp_t q[$];
  int vec = 0, bad = 0;

  // Reference model: memory contents, port registers, pin history two edges deep
  logic [7:0] mm [256];
  logic [7:0] mo [16];
  logic [7:0] p1 [16];
  logic [7:0] p2 [16];
  logic [7:0] mfm, mmar;
  logic mre, mue;

  function automatic bit is_out(input logic [7:0] a);
    return a[7:4] == 4'hE && int'(a[3:0]) < N;
  endfunction
  function automatic bit is_in(input logic [7:0] a);
    return a[7:4] == 4'hF && int'(a[3:0]) < N;
  endfunction
  function automatic logic [7:0] m_read(input logic [7:0] a);
    if (a <= RAM_TOP) return mm[a];
    if (is_out(a)) return mo[a[3:0]];
    if (is_in(a)) return p2[a[3:0]];
    return 8'h00;
  endfunction
  function automatic logic [8*N-1:0] m_po();
    logic [8*N-1:0] v;
    for (int k = 0; k < N; k++) v[8*k +: 8] = mo[k];
    return v;
  endfunction

  task automatic m_reset();
    mfm = 0; mmar = 0; mre = 0; mue = 0;
    for (int k = 0; k < 16; k++) begin mo[k] = 0; p1[k] = 0; p2[k] = 0; end
  endtask

  task automatic step(input bit ml, input logic [7:0] a, input bit wr, input logic [7:0] d,
                      input bit pw, input logic [7:0] pa, input logic [7:0] pd,
                      input logic [8*N-1:0] pins, input string tag);
    logic [7:0] rd, nfm;
    exp_t e;
    @(negedge clk);
    mar_load = ml; addr_in = a; write = wr; data_in = d;
    prog_we = pw; prog_addr = pa; prog_data = pd; port_in = pins;
    rd = m_read(a);
    nfm = mfm;
    if (ml && !(a <= RAM_TOP || is_out(a) || is_in(a))) mue = 1;
    if (wr) begin
      if (mmar <= ROM_TOP) mre = 1;
      else if (mmar <= RAM_TOP) begin mm[mmar] = d; nfm = d; end
      else if (is_out(mmar)) begin mo[mmar[3:0]] = d; nfm = d; end
      else if (!is_in(mmar)) mue = 1;
    end
    if (pw && pa <= RAM_TOP) mm[pa] = pd;
    if (ml) begin nfm = rd; mmar = a; end
    mfm = nfm;
    for (int k = 0; k < 16; k++) p2[k] = p1[k];
    for (int k = 0; k < N; k++) p1[k] = pins[8*k +: 8];
    e.fm = mfm; e.mar = mmar; e.po = m_po(); e.re = mre; e.ue = mue; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic rd_a(input logic [7:0] a, input string tag);
    step(1, a, 0, 0, 0, 0, 0, port_in, tag);
  endtask
  task automatic wr_d(input logic [7:0] d, input string tag);
    step(0, 0, 1, d, 0, 0, 0, port_in, tag);
  endtask
  task automatic pl(input logic [7:0] a, input logic [7:0] d);
    step(0, 0, 0, 0, 1, a, d, port_in, "pload");
  endtask

  task automatic chk_reset(input string tag);
    vec++;
    if (from_memory !== 0 || mar_out !== 0 || port_out !== 0 || rom_wr_err !== 0 || unmapped_err !== 0) begin
      bad++;
      $display("FAIL %s: got fm=%h mar=%h po=%h re=%b ue=%b, want all zero",
               tag, from_memory, mar_out, port_out, rom_wr_err, unmapped_err);
    end
  endtask

  // Monitor: one expectation per driven edge, checked just after that edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vec++;
      if (from_memory !== e.fm || mar_out !== e.mar || port_out !== e.po ||
          rom_wr_err !== e.re || unmapped_err !== e.ue) begin
        bad++;
        $display("FAIL %s: got fm=%h mar=%h po=%h re=%b ue=%b, want fm=%h mar=%h po=%h re=%b ue=%b",
                 e.tag, from_memory, mar_out, port_out, rom_wr_err, unmapped_err,
                 e.fm, e.mar, e.po, e.re, e.ue);
      end
    end
  end

  function automatic logic [7:0] rnd_addr();
    case ($urandom_range(0, 4))
      0: return 8'($urandom_range(0, int'(ROM_TOP)));
      1, 2: return 8'($urandom_range(int'(ROM_TOP) + 1, int'(RAM_TOP)));
      3: return 8'hE0 + 8'($urandom_range(0, 15));
      default: return 8'hF0 + 8'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    m_reset();
    #1 chk_reset("reset_init");
    #20;
    @(negedge clk) reset = 0;
    for (int a = 0; a <= int'(RAM_TOP); a++) pl(8'(a), 8'($urandom));
    pl(8'h00, 8'h80); pl(8'h01, 8'h03);
    rd_a(8'h00, "fetch00"); rd_a(8'h01, "fetch01");
    rd_a(8'hA0, "ram_sel"); wr_d(8'h5C, "ram_wt"); rd_a(8'h00, "ram_away"); rd_a(8'hA0, "ram_back");
    pl(8'h10, 8'h42); rd_a(8'h10, "rom_rd"); wr_d(8'hFF, "rom_prot"); rd_a(8'h10, "rom_reread");
    rd_a(8'hE1, "out_sel"); wr_d(8'h3C, "out_wr");
    step(0, 0, 0, 0, 0, 0, 0, 32'h0000_009A, "pin_s1");
    step(0, 0, 0, 0, 0, 0, 0, 32'h0000_009A, "pin_s2");
    rd_a(8'hF0, "in_rd");
    step(0, 0, 0, 0, 0, 0, 0, 32'h0000_0011, "pin_chg");
    step(0, 0, 0, 0, 0, 0, 0, 32'h0000_0011, "in_hold");
    rd_a(8'hEF, "unmapped");
    pl(8'hA2, 8'h22); rd_a(8'hA1, "sim_sel");
    step(1, 8'hA2, 1, 8'h11, 0, 0, 0, port_in, "simult");
    rd_a(8'hA1, "sim_check");
    step(0, 0, 0, 0, 1, 8'hE5, 8'h77, port_in, "pload_hi");
    rd_a(8'hB0, "coll_sel");
    step(0, 0, 1, 8'h01, 1, 8'hB0, 8'h02, port_in, "coll");
    rd_a(8'hB0, "coll_check");
    for (int i = 0; i < 600; i++) begin
      logic [8*N-1:0] pins;
      pins = ($urandom_range(0, 3) == 0) ? {$urandom} : port_in;
      step($urandom_range(0, 2) == 0, rnd_addr(), $urandom_range(0, 3) == 0, 8'($urandom),
           $urandom_range(0, 7) == 0, 8'($urandom), 8'($urandom), pins, "rand");
    end
    rd_a(8'hA5, "pre_sel"); wr_d(8'h77, "pre_ram");
    rd_a(8'hE2, "pre_osel"); wr_d(8'h99, "pre_out");
    step(0, 0, 0, 0, 0, 0, 0, 0, "idle");
    step(0, 0, 0, 0, 0, 0, 0, 0, "idle");
    @(negedge clk);
    #2 reset = 1;
    #1 chk_reset("reset_async");
    m_reset();
    repeat (2) @(negedge clk);
    reset = 0;
    rd_a(8'hA5, "post_ram");
    rd_a(8'hE2, "post_out");
    rd_a(8'h10, "post_rom");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      vec++; bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Target side of the control unit's memory interface.
- Captures the address on the MAR strobe and returns read data in time for the next-cycle IR/operand capture. Performs stores on the write strobe.
- Decodes the 8-bit address space into program ROM, data RAM and memory-mapped I/O.
- Also provides a load port so a test bench or boot loader can fill program memory.

Parameters:
- ROM_TOP, 8'h7F, highest ROM address; ROM occupies 8'h00..ROM_TOP.
- RAM_TOP, 8'hDF, highest RAM address; RAM occupies ROM_TOP+1..RAM_TOP.
- N_PORTS, 4, number of output ports at 8'hE0.. and input ports at 8'hF0.. (1..16).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-high.
- mar_load, input, 1, latch addr_in into MAR and fetch read data.
- addr_in, input, 8, address from the processor bus.
- write, input, 1, store data_in at the current MAR.
- data_in, input, 8, store data from the processor bus.
- from_memory, output, 8, registered read data.
- prog_we, input, 1, program-load write strobe.
- prog_addr, input, 8, program-load address.
- prog_data, input, 8, program-load data.
- port_in, input, 8*N_PORTS, asynchronous input pins; port k is bits [8k+7:8k].
- port_out, output, 8*N_PORTS, output port registers.
- mar_out, output, 8, current MAR (debug).
- rom_wr_err, output, 1, sticky: CPU attempted a store to ROM.
- unmapped_err, output, 1, sticky: access to an unmapped I/O address.

Behaviour:
- Reset (async, active-high):
  - MAR, from_memory and port_out are 0.
  - Both error flags are 0.
  - Input synchronizers are 0.
  - ROM and RAM contents are not cleared.
- Memory array: one 256x8 array backs both ROM and RAM.
- Address map:
  - ROM: 8'h00..ROM_TOP.
  - RAM: ROM_TOP+1..RAM_TOP.
  - OUT: 8'hE0..8'hE0+N_PORTS-1.
  - IN: 8'hF0..8'hF0+N_PORTS-1.
  - Anything else in 8'hE0..8'hFF is unmapped.
- Read (mar_load=1 at edge N):
  - MAR <= addr_in.
  - from_memory <= data at addr_in, stable from after edge N until the next mar_load or write. Latency is one cycle, with no wait states.
  - ROM/RAM region: array contents.
  - OUT region: port_out[k].
  - IN region: the second synchronizer stage of port k.
  - Unmapped region: 8'h00, and unmapped_err <= 1.
- Input synchronizers:
  - Two flops per port on clk; the IN value is 2 cycles behind the pins.
  - from_memory holds its captured value; it does not track later pin changes.
- Write (write=1 at an edge) applies to the current MAR, not addr_in:
  - RAM: array[MAR] <= data_in; from_memory <= data_in (write-through).
  - OUT: port_out[k] <= data_in; from_memory <= data_in.
  - ROM: no array change, from_memory unchanged, rom_wr_err <= 1.
  - IN or unmapped: ignored, and unmapped_err <= 1 for unmapped addresses.
- Simultaneous mar_load and write at the same edge:
  - The write uses the old MAR.
  - MAR and from_memory take the new read (read wins for from_memory).
- Program load:
  - prog_we=1: array[prog_addr] <= prog_data for any address in 0..RAM_TOP, ROM included. Addresses above RAM_TOP are ignored.
  - prog_we does not touch MAR, from_memory or the error flags.
  - If prog_we and a CPU write target the same array address at the same edge, prog_we wins.
- Error flags: sticky; cleared only by reset.
- Reset mid-operation: outputs go to reset values immediately (async assert). The first edge after deassertion behaves normally.
- MAR arithmetic: 8-bit with no increment logic inside this block. The processor's PC handles wrap 8'hFF->8'h00.

Test Plan:
- Program load then fetch: prog_we writes 8'h80@00, 8'h03@01. mar_load addr 00 -> from_memory=8'h80 one edge later; mar_load addr 01 -> 8'h03.
- RAM store/read: mar_load 8'hA0, then write data_in=8'h5C -> from_memory=8'h5C at once. mar_load 8'h00 then mar_load 8'hA0 -> 8'h5C.
- ROM protect: mar_load 8'h10 (holding 8'h42), write 8'hFF -> from_memory stays 8'h42, rom_wr_err=1. Re-read 8'h10 -> 8'h42.
- I/O: write 8'h3C to 8'hE1 -> port_out[15:8]=8'h3C. Set port_in[7:0]=8'h9A, wait 2 clocks, mar_load 8'hF0 -> 8'h9A. Read 8'hEF -> 8'h00 and unmapped_err=1.
- Simultaneous: MAR=8'hA1, same edge write=1 (data 8'h11) and mar_load addr 8'hA2 (holding 8'h22) -> array[A1]=8'h11, MAR=8'hA2, from_memory=8'h22.
- Async reset mid-write sequence: assert reset between edges -> port_out=0, from_memory=0, flags=0 immediately. RAM contents written before reset read back unchanged after release.
